mips_exec_ctrl: RTL and testbench

MIPS_EXEC_CTRL -- requirements
Module: mips_exec_ctrl

---
 rtl/mips_exec_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mips_exec_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_exec_ctrl
// Description : Single-cycle MIPS main decoder, ALU control and ALU with every
//               output registered (exactly one clock of latency).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_exec_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        reg_dst,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic        jump,
  output logic [2:0]  alu_op,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        zero
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_XORI  = 6'b001110;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;

  localparam logic [3:0] c_ALU_AND  = 4'b0000;
  localparam logic [3:0] c_ALU_OR   = 4'b0001;
  localparam logic [3:0] c_ALU_ADD  = 4'b0010;
  localparam logic [3:0] c_ALU_XOR  = 4'b0011;
  localparam logic [3:0] c_ALU_LUI  = 4'b0100;
  localparam logic [3:0] c_ALU_SUB  = 4'b0110;
  localparam logic [3:0] c_ALU_SLT  = 4'b0111;
  localparam logic [3:0] c_ALU_SLTU = 4'b1000;
  localparam logic [3:0] c_ALU_SLL  = 4'b1001;
  localparam logic [3:0] c_ALU_SRL  = 4'b1010;
  localparam logic [3:0] c_ALU_SRA  = 4'b1011;
  localparam logic [3:0] c_ALU_NOR  = 4'b1100;
  localparam logic [3:0] c_ALU_BAD  = 4'b1111;

  // Control bundle order: reg_dst, alu_src, mem_to_reg, reg_write,
  //                       mem_read, mem_write, branch, jump
  logic [7:0]  w_ctl;
  logic [2:0]  w_alu_op;
  logic [3:0]  w_alu_ctrl;
  logic [31:0] w_imm_ext;
  logic [31:0] w_opb;
  logic [31:0] w_result;
  logic        w_zext;

  logic [7:0]  r_ctl;
  logic [2:0]  r_alu_op;
  logic [3:0]  r_alu_ctrl;
  logic [31:0] r_result;
  logic        r_zero;

  // Main decoder: opcode to control bundle and ALU class
  always_comb begin
    w_ctl    = 8'b0000_0000;
    w_alu_op = 3'b000;
    case (opcode)
      c_OP_RTYPE: begin w_ctl = 8'b1001_0000; w_alu_op = 3'b010; end
      c_OP_LW:    begin w_ctl = 8'b0111_1000; w_alu_op = 3'b000; end
      c_OP_SW:    begin w_ctl = 8'b0100_0100; w_alu_op = 3'b000; end
      c_OP_BEQ:   begin w_ctl = 8'b0000_0010; w_alu_op = 3'b001; end
      c_OP_J:     begin w_ctl = 8'b0000_0001; w_alu_op = 3'b000; end
      c_OP_ADDI:  begin w_ctl = 8'b0101_0000; w_alu_op = 3'b000; end
      c_OP_ANDI:  begin w_ctl = 8'b0101_0000; w_alu_op = 3'b011; end
      c_OP_ORI:   begin w_ctl = 8'b0101_0000; w_alu_op = 3'b100; end
      c_OP_SLTI:  begin w_ctl = 8'b0101_0000; w_alu_op = 3'b101; end
      c_OP_XORI:  begin w_ctl = 8'b0101_0000; w_alu_op = 3'b110; end
      c_OP_LUI:   begin w_ctl = 8'b0101_0000; w_alu_op = 3'b111; end
      default:    begin w_ctl = 8'b0000_0000; w_alu_op = 3'b000; end
    endcase
  end

  // ALU control: ALU class (and func for R-type) to ALU operation
  always_comb begin
    w_alu_ctrl = c_ALU_ADD;
    case (w_alu_op)
      3'b000: w_alu_ctrl = c_ALU_ADD;
      3'b001: w_alu_ctrl = c_ALU_SUB;
      3'b011: w_alu_ctrl = c_ALU_AND;
      3'b100: w_alu_ctrl = c_ALU_OR;
      3'b101: w_alu_ctrl = c_ALU_SLT;
      3'b110: w_alu_ctrl = c_ALU_XOR;
      3'b111: w_alu_ctrl = c_ALU_LUI;
      default: begin
        case (func)
          6'b100000, 6'b100001: w_alu_ctrl = c_ALU_ADD;
          6'b100010, 6'b100011: w_alu_ctrl = c_ALU_SUB;
          6'b100100:            w_alu_ctrl = c_ALU_AND;
          6'b100101:            w_alu_ctrl = c_ALU_OR;
          6'b100110:            w_alu_ctrl = c_ALU_XOR;
          6'b100111:            w_alu_ctrl = c_ALU_NOR;
          6'b101010:            w_alu_ctrl = c_ALU_SLT;
          6'b101011:            w_alu_ctrl = c_ALU_SLTU;
          6'b000000:            w_alu_ctrl = c_ALU_SLL;
          6'b000010:            w_alu_ctrl = c_ALU_SRL;
          6'b000011:            w_alu_ctrl = c_ALU_SRA;
          default:              w_alu_ctrl = c_ALU_BAD;
        endcase
      end
    endcase
  end

  // Logical immediates are zero-extended, everything else sign-extended
  assign w_zext    = (opcode == c_OP_ANDI) || (opcode == c_OP_ORI) || (opcode == c_OP_XORI);
  assign w_imm_ext = w_zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
  assign w_opb     = w_ctl[6] ? w_imm_ext : rt_data;

  // ALU: unknown operation codes yield zero
  always_comb begin
    w_result = 32'h0000_0000;
    case (w_alu_ctrl)
      c_ALU_ADD:  w_result = rs_data + w_opb;
      c_ALU_SUB:  w_result = rs_data - w_opb;
      c_ALU_AND:  w_result = rs_data & w_opb;
      c_ALU_OR:   w_result = rs_data | w_opb;
      c_ALU_XOR:  w_result = rs_data ^ w_opb;
      c_ALU_NOR:  w_result = ~(rs_data | w_opb);
      c_ALU_SLT:  w_result = {31'd0, $signed(rs_data) < $signed(w_opb)};
      c_ALU_SLTU: w_result = {31'd0, rs_data < w_opb};
      c_ALU_LUI:  w_result = {w_opb[15:0], 16'h0000};
      c_ALU_SLL:  w_result = w_opb << shamt;
      c_ALU_SRL:  w_result = w_opb >> shamt;
      c_ALU_SRA:  w_result = $unsigned($signed(w_opb) >>> shamt);
      default:    w_result = 32'h0000_0000;
    endcase
  end

  // Output register stage; reset clears every output including zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctl      <= 8'b0000_0000;
      r_alu_op   <= 3'b000;
      r_alu_ctrl <= 4'b0000;
      r_result   <= 32'h0000_0000;
      r_zero     <= 1'b0;
    end else begin
      r_ctl      <= w_ctl;
      r_alu_op   <= w_alu_op;
      r_alu_ctrl <= w_alu_ctrl;
      r_result   <= w_result;
      r_zero     <= (w_result == 32'h0000_0000);
    end
  end

  assign reg_dst    = r_ctl[7];
  assign alu_src    = r_ctl[6];
  assign mem_to_reg = r_ctl[5];
  assign reg_write  = r_ctl[4];
  assign mem_read   = r_ctl[3];
  assign mem_write  = r_ctl[2];
  assign branch     = r_ctl[1];
  assign jump       = r_ctl[0];
  assign alu_op     = r_alu_op;
  assign alu_ctrl   = r_alu_ctrl;
  assign alu_result = r_result;
  assign zero       = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_mips_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_exec_ctrl
// Description : Scoreboard bench for mips_exec_ctrl (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_exec_ctrl;

  typedef struct packed {
    logic [7:0]  ctl;   // reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,jump
    logic [2:0]  aop;
    logic [3:0]  actl;
    logic [31:0] res;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jump;
  logic [2:0]  alu_op;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  mips_exec_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .shamt(shamt),
    .imm16(imm16), .rs_data(rs_data), .rt_data(rt_data),
    .reg_dst(reg_dst), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .jump(jump),
    .alu_op(alu_op), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .zero(zero)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model of decode, ALU control and ALU
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                 input logic [15:0] im, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] bb;
    e = '0;
    case (op)
      6'h00: begin e.ctl = 8'b1001_0000; e.aop = 3'd2; end
      6'h23: begin e.ctl = 8'b0111_1000; e.aop = 3'd0; end
      6'h2B: begin e.ctl = 8'b0100_0100; e.aop = 3'd0; end
      6'h04: begin e.ctl = 8'b0000_0010; e.aop = 3'd1; end
      6'h02: begin e.ctl = 8'b0000_0001; e.aop = 3'd0; end
      6'h08: begin e.ctl = 8'b0101_0000; e.aop = 3'd0; end
      6'h0C: begin e.ctl = 8'b0101_0000; e.aop = 3'd3; end
      6'h0D: begin e.ctl = 8'b0101_0000; e.aop = 3'd4; end
      6'h0A: begin e.ctl = 8'b0101_0000; e.aop = 3'd5; end
      6'h0E: begin e.ctl = 8'b0101_0000; e.aop = 3'd6; end
      6'h0F: begin e.ctl = 8'b0101_0000; e.aop = 3'd7; end
      default: ;
    endcase
    if (!e.ctl[6])                               bb = b;
    else if (op == 6'h0C || op == 6'h0D || op == 6'h0E) bb = {16'h0, im};
    else                                         bb = {{16{im[15]}}, im};
    case (e.aop)
      3'd0: e.actl = 4'h2;
      3'd1: e.actl = 4'h6;
      3'd3: e.actl = 4'h0;
      3'd4: e.actl = 4'h1;
      3'd5: e.actl = 4'h7;
      3'd6: e.actl = 4'h3;
      3'd7: e.actl = 4'h4;
      default:
        case (fn)
          6'h20, 6'h21: e.actl = 4'h2;
          6'h22, 6'h23: e.actl = 4'h6;
          6'h24: e.actl = 4'h0;
          6'h25: e.actl = 4'h1;
          6'h26: e.actl = 4'h3;
          6'h27: e.actl = 4'hC;
          6'h2A: e.actl = 4'h7;
          6'h2B: e.actl = 4'h8;
          6'h00: e.actl = 4'h9;
          6'h02: e.actl = 4'hA;
          6'h03: e.actl = 4'hB;
          default: e.actl = 4'hF;
        endcase
    endcase
    case (e.actl)
      4'h2: e.res = a + bb;
      4'h6: e.res = a - bb;
      4'h0: e.res = a & bb;
      4'h1: e.res = a | bb;
      4'h3: e.res = a ^ bb;
      4'hC: e.res = ~(a | bb);
      4'h7: e.res = (int'(a) < int'(bb)) ? 32'd1 : 32'd0;
      4'h8: e.res = (a < bb) ? 32'd1 : 32'd0;
      4'h4: e.res = bb << 16;
      4'h9: e.res = bb << sh;
      4'hA: e.res = bb >> sh;
      4'hB: begin
        e.res = bb;
        for (int i = 0; i < 32; i++) if (i < int'(sh)) e.res = {bb[31], e.res[31:1]};
      end
      default: e.res = 32'd0;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check_out(input string name);
    exp_t e;
    if (q.size() == 0) begin
      chk({name, ":scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    chk({name, ":ctl"}, {24'd0, reg_dst, alu_src, mem_to_reg, reg_write,
                         mem_read, mem_write, branch, jump}, {24'd0, e.ctl});
    chk({name, ":alu_op"},   {29'd0, alu_op},   {29'd0, e.aop});
    chk({name, ":alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, e.actl});
    chk({name, ":result"},   alu_result,        e.res);
    chk({name, ":zero"},     {31'd0, zero},     {31'd0, e.z});
  endtask

  // Drive one instruction, push its expectation, compare one edge later
  task automatic apply(input string name, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [15:0] im, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
    @(negedge clk);
    reset = rst; opcode = op; func = fn; shamt = sh; imm16 = im; rs_data = a; rt_data = b;
    q.push_back(e);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  function automatic exp_t mk(input logic [7:0] c, input logic [2:0] ao, input logic [3:0] ac,
                              input logic [31:0] r);
    exp_t e;
    e.ctl = c; e.aop = ao; e.actl = ac; e.res = r; e.z = (r == 32'd0);
    return e;
  endfunction

  logic [5:0] ops [12] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08,
                           6'h0C, 6'h0D, 6'h0A, 6'h0E, 6'h0F, 6'h3F};
  logic [5:0] fns [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                           6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

  initial begin
    reset = 1'b1; opcode = '0; func = '0; shamt = '0; imm16 = '0; rs_data = '0; rt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", alu_result, 32'd0);
    chk("reset_ctl", {21'd0, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                      branch, jump, alu_op}, 32'd0);

    // Reset held while the add stimulus is present: everything stays zero
    apply("rst_add", 1'b1, 6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7, '0);
    // First live capture right after reset
    apply("add",  1'b0, 6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7, mk(8'b1001_0000, 3'd2, 4'h2, 32'd12));

    // Inputs changing mid-cycle must not disturb registered outputs
    #2 rs_data = 32'd100;
    @(negedge clk);
    chk("hold_result", alu_result, 32'd12);

    apply("beq",  1'b0, 6'h04, 6'h00, 5'd0, 16'h0, 32'h1234, 32'h1234, mk(8'b0000_0010, 3'd1, 4'h6, 32'd0));
    apply("lw",   1'b0, 6'h23, 6'h00, 5'd0, 16'hFFFC, 32'h100, 32'd9, mk(8'b0111_1000, 3'd0, 4'h2, 32'hFC));
    apply("ori",  1'b0, 6'h0D, 6'h00, 5'd0, 16'h80F0, 32'h0F00, 32'd0, mk(8'b0101_0000, 3'd4, 4'h1, 32'h8FF0));
    apply("slti", 1'b0, 6'h0A, 6'h00, 5'd0, 16'h0001, 32'hFFFF_FFFF, 32'd0, mk(8'b0101_0000, 3'd5, 4'h7, 32'd1));
    apply("sra",  1'b0, 6'h00, 6'h03, 5'd4, 16'h0, 32'd0, 32'h8000_0000, mk(8'b1001_0000, 3'd2, 4'hB, 32'hF800_0000));
    apply("illegal", 1'b0, 6'h3F, 6'h20, 5'd0, 16'h0, 32'd3, 32'd4, mk(8'h00, 3'd0, 4'h2, 32'd7));
    apply("sub_wrap", 1'b0, 6'h00, 6'h22, 5'd0, 16'h0, 32'd0, 32'd1, mk(8'b1001_0000, 3'd2, 4'h6, 32'hFFFF_FFFF));
    apply("nor",  1'b0, 6'h00, 6'h27, 5'd0, 16'h0, 32'hF0F0_F0F0, 32'h0F0F_0000, mk(8'b1001_0000, 3'd2, 4'hC, 32'h0000_0F0F));
    apply("sltu", 1'b0, 6'h00, 6'h2B, 5'd0, 16'h0, 32'd1, 32'hFFFF_FFFF, mk(8'b1001_0000, 3'd2, 4'h8, 32'd1));
    apply("badfn", 1'b0, 6'h00, 6'h3F, 5'd0, 16'h0, 32'd1, 32'd2, mk(8'b1001_0000, 3'd2, 4'hF, 32'd0));
    apply("lui",  1'b0, 6'h0F, 6'h00, 5'd0, 16'hABCD, 32'h1234_5678, 32'd0, mk(8'b0101_0000, 3'd7, 4'h4, 32'hABCD_0000));
    apply("andi", 1'b0, 6'h0C, 6'h00, 5'd0, 16'h8001, 32'hFFFF_FFFF, 32'd0, mk(8'b0101_0000, 3'd3, 4'h0, 32'h0000_8001));
    apply("xori", 1'b0, 6'h0E, 6'h00, 5'd0, 16'hFFFF, 32'h0000_FFFF, 32'd0, mk(8'b0101_0000, 3'd6, 4'h3, 32'd0));
    apply("sw",   1'b0, 6'h2B, 6'h00, 5'd0, 16'h8000, 32'h10, 32'd5, mk(8'b0100_0100, 3'd0, 4'h2, 32'hFFFF_8010));
    apply("j",    1'b0, 6'h02, 6'h00, 5'd0, 16'h0, 32'd1, 32'd2, mk(8'b0000_0001, 3'd0, 4'h2, 32'd3));
    apply("sll",  1'b0, 6'h00, 6'h00, 5'd31, 16'h0, 32'd0, 32'd3, mk(8'b1001_0000, 3'd2, 4'h9, 32'h8000_0000));
    apply("srl",  1'b0, 6'h00, 6'h02, 5'd1, 16'h0, 32'd0, 32'h8000_0000, mk(8'b1001_0000, 3'd2, 4'hA, 32'h4000_0000));
    apply("addi_ovf", 1'b0, 6'h08, 6'h00, 5'd0, 16'h0001, 32'h7FFF_FFFF, 32'd0, mk(8'b0101_0000, 3'd0, 4'h2, 32'h8000_0000));

    // Randomised sweep checked against the reference model
    for (int k = 0; k < 60; k++) begin
      logic [5:0]  op, fn;
      logic [4:0]  sh;
      logic [15:0] im;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 12)];
      sh = 5'($urandom);
      im = 16'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 32'(im) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      apply("rand", 1'b0, op, fn, sh, im, a, b, model(op, fn, sh, im, a, b));
    end

    // Reset again mid-stream with live stimulus
    apply("rst_mid", 1'b1, 6'h23, 6'h00, 5'd0, 16'h0004, 32'd8, 32'd0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
